// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - boot-time image loader for instruction and data BRAMs
module boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int I_DEPTH    = 256,
  parameter int D_DEPTH    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic [ADDR_WIDTH-1:0] ld_d_w_addr,
  output logic [DATA_WIDTH-1:0] ld_d_w_dat,
  output logic                  ld_d_w_enb,
  output logic                  d_bram_init_done,
  output logic                  pc_stall,
  output logic                  busy,
  output logic                  error,
  output logic                  done
);

  localparam int CW = ADDR_WIDTH - 2;
  localparam logic [16:0] I_MAX = 17'(I_DEPTH);
  localparam logic [16:0] D_MAX = 17'(D_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HEADER, ST_LOAD_I, ST_LOAD_D, ST_FLUSH, ST_RUN, ST_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [15:0]           n_i_q, n_i_d, n_d_q, n_d_d;
  logic                  i_enb_q, i_enb_d, d_enb_q, d_enb_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
  logic [DATA_WIDTH-1:0] i_dat_q, i_dat_d, d_dat_q, d_dat_d;

  logic        accept;
  logic [15:0] hdr_i, hdr_d, cnt_ext;

  assign accept  = s_valid && s_ready;
  assign hdr_i   = s_data[31:16];
  assign hdr_d   = s_data[15:0];
  assign cnt_ext = 16'(cnt_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      n_i_q    <= '0;
      n_d_q    <= '0;
      i_enb_q  <= 1'b0;
      d_enb_q  <= 1'b0;
      done_q   <= 1'b0;
      i_addr_q <= '0;
      d_addr_q <= '0;
      i_dat_q  <= '0;
      d_dat_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_i_q    <= n_i_d;
      n_d_q    <= n_d_d;
      i_enb_q  <= i_enb_d;
      d_enb_q  <= d_enb_d;
      done_q   <= done_d;
      i_addr_q <= i_addr_d;
      d_addr_q <= d_addr_d;
      i_dat_q  <= i_dat_d;
      d_dat_q  <= d_dat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_i_d    = n_i_q;
    n_d_d    = n_d_q;
    i_enb_d  = 1'b0;
    d_enb_d  = 1'b0;
    done_d   = 1'b0;
    i_addr_d = i_addr_q;
    d_addr_d = d_addr_q;
    i_dat_d  = i_dat_q;
    d_dat_d  = d_dat_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_HEADER;
      ST_HEADER: if (accept) begin
        n_i_d = hdr_i;
        n_d_d = hdr_d;
        cnt_d = '0;
        if (hdr_i == 16'd0 || {1'b0, hdr_i} > I_MAX || {1'b0, hdr_d} > D_MAX)
          state_d = ST_ERROR;
        else
          state_d = ST_LOAD_I;
      end
      ST_LOAD_I: if (accept) begin
        i_enb_d  = 1'b1;
        i_addr_d = {cnt_q, 2'b00};
        i_dat_d  = s_data;
        if (cnt_ext == n_i_q - 16'd1) begin
          cnt_d   = '0;
          state_d = (n_d_q != 16'd0) ? ST_LOAD_D : ST_FLUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD_D: if (accept) begin
        d_enb_d  = 1'b1;
        d_addr_d = {cnt_q, 2'b00};
        d_dat_d  = s_data;
        if (cnt_ext == n_d_q - 16'd1) begin
          cnt_d   = '0;
          state_d = ST_FLUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
        done_d  = 1'b1;
      end
      ST_RUN, ST_ERROR: if (start) state_d = ST_HEADER;
      default: state_d = ST_IDLE;
    endcase
  end

  // In RUN, start hands the data port back to the loader combinationally.
  always_comb begin
    s_ready          = 1'b0;
    busy             = 1'b0;
    error            = 1'b0;
    pc_stall         = 1'b1;
    d_bram_init_done = 1'b0;
    case (state_q)
      ST_HEADER, ST_LOAD_I, ST_LOAD_D: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      ST_FLUSH: busy = 1'b1;
      ST_RUN: begin
        pc_stall         = start;
        d_bram_init_done = !start;
      end
      ST_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign i_w_enb     = i_enb_q;
  assign i_w_addr    = i_addr_q;
  assign i_w_dat     = i_dat_q;
  assign ld_d_w_enb  = d_enb_q;
  assign ld_d_w_addr = d_addr_q;
  assign ld_d_w_dat  = d_dat_q;
  assign done        = done_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed self-checking bench for boot_loader
module tb_boot_loader;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, i_w_enb, ld_d_w_enb, d_bram_init_done, pc_stall, busy, error, done;
  logic [AW-1:0] i_w_addr, ld_d_w_addr;
  logic [DW-1:0] i_w_dat, ld_d_w_dat;

  boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .I_DEPTH(256), .D_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .ld_d_w_addr(ld_d_w_addr), .ld_d_w_dat(ld_d_w_dat), .ld_d_w_enb(ld_d_w_enb),
    .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall), .busy(busy),
    .error(error), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] iw_a[$], iw_d[$], dw_a[$], dw_d[$];
  int both_hi = 0, orphan = 0, strobe_cnt = 0, acc_cnt = 0;
  logic acc_prev = 1'b0;

  always @(posedge clk) begin
    acc_prev <= rst && s_valid && s_ready;
    if (rst && s_valid && s_ready) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clk) begin
    if (i_w_enb) begin iw_a.push_back(32'(i_w_addr)); iw_d.push_back(i_w_dat); end
    if (ld_d_w_enb) begin dw_a.push_back(32'(ld_d_w_addr)); dw_d.push_back(ld_d_w_dat); end
    if (i_w_enb && ld_d_w_enb) both_hi = both_hi + 1;
    if ((i_w_enb || ld_d_w_enb) && !acc_prev) orphan = orphan + 1;
    if (i_w_enb || ld_d_w_enb) strobe_cnt = strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input int gap);
    int waited = 0;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) tick();
    end
    s_valid = 1'b1;
    s_data  = d;
    while (s_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) begin
      check("send_timeout_s_ready", 32'(s_ready), 32'd1);
      return;
    end
    tick();
  endtask

  task automatic load(input logic [31:0] hdr, input logic [31:0] ib, input logic [31:0] db,
                      input bit gaps);
    int ni = int'(hdr[31:16]);
    int nd = int'(hdr[15:0]);
    send(hdr, gaps ? int'($urandom_range(0, 3)) : 0);
    for (int k = 0; k < ni; k++) send(ib + 32'(k), gaps ? int'($urandom_range(0, 3)) : 0);
    for (int j = 0; j < nd; j++) send(db + 32'(j), gaps ? int'($urandom_range(0, 3)) : 0);
    s_valid = 1'b0;
  endtask

  // Called at the FLUSH cycle that follows the final accept edge.
  task automatic finish_check(input string t);
    check({t, "_flush_busy"}, 32'(busy), 32'd1);
    check({t, "_flush_s_ready"}, 32'(s_ready), 32'd0);
    check({t, "_flush_done"}, 32'(done), 32'd0);
    check({t, "_flush_pc_stall"}, 32'(pc_stall), 32'd1);
    tick();
    check({t, "_run_done"}, 32'(done), 32'd1);
    check({t, "_run_pc_stall"}, 32'(pc_stall), 32'd0);
    check({t, "_run_dinit"}, 32'(d_bram_init_done), 32'd1);
    check({t, "_run_busy"}, 32'(busy), 32'd0);
    tick();
    check({t, "_done_pulse_end"}, 32'(done), 32'd0);
  endtask

  task automatic check_writes(input string t, input bit is_i, input int base, input int n,
                              input logic [31:0] dbase);
    int sz = is_i ? iw_a.size() : dw_a.size();
    check({t, "_count"}, 32'(sz - base), 32'(n));
    if (sz - base != n) return;
    for (int k = 0; k < n; k++) begin
      check({t, "_addr"}, is_i ? iw_a[base+k] : dw_a[base+k], 32'(k * 4));
      check({t, "_data"}, is_i ? iw_d[base+k] : dw_d[base+k], dbase + 32'(k));
    end
  endtask

  task automatic check_reset_vals(input string t);
    check({t, "_s_ready"}, 32'(s_ready), 32'd0);
    check({t, "_i_enb"}, 32'(i_w_enb), 32'd0);
    check({t, "_i_addr"}, 32'(i_w_addr), 32'd0);
    check({t, "_i_dat"}, i_w_dat, 32'd0);
    check({t, "_d_enb"}, 32'(ld_d_w_enb), 32'd0);
    check({t, "_d_addr"}, 32'(ld_d_w_addr), 32'd0);
    check({t, "_d_dat"}, ld_d_w_dat, 32'd0);
    check({t, "_pc_stall"}, 32'(pc_stall), 32'd1);
    check({t, "_dinit"}, 32'(d_bram_init_done), 32'd0);
    check({t, "_busy"}, 32'(busy), 32'd0);
    check({t, "_error"}, 32'(error), 32'd0);
    check({t, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ib, db, sb, ab;

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b1;
    tick();
    check("idle_s_ready", 32'(s_ready), 32'd0);

    // 7/2 load, back to back
    pulse_start();
    check("header_s_ready", 32'(s_ready), 32'd1);
    check("header_busy", 32'(busy), 32'd1);
    ib = iw_a.size();
    db = dw_a.size();
    load(32'h0007_0002, 32'hA000_0000, 32'hB000_0000, 1'b0);
    finish_check("l72");
    check_writes("l72_i", 1'b1, ib, 7, 32'hA000_0000);
    check_writes("l72_d", 1'b0, db, 2, 32'hB000_0000);

    // start in RUN drops the core handoff in the same cycle; then a 3/0 image
    start = 1'b1;
    #1;
    check("reload_pc_stall", 32'(pc_stall), 32'd1);
    check("reload_dinit", 32'(d_bram_init_done), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("reload_header_s_ready", 32'(s_ready), 32'd1);
    ib = iw_a.size();
    db = dw_a.size();
    load(32'h0003_0000, 32'hC000_0000, 32'h0, 1'b0);
    finish_check("l30");
    check_writes("l30_i", 1'b1, ib, 3, 32'hC000_0000);
    check("l30_no_d_writes", 32'(dw_a.size() - db), 32'd0);

    // Header rejected: too many instruction words
    pulse_start();
    send(32'h0101_0000, 0);
    check("err1_error", 32'(error), 32'd1);
    check("err1_s_ready", 32'(s_ready), 32'd0);
    check("err1_busy", 32'(busy), 32'd0);
    sb = strobe_cnt;
    ab = acc_cnt;
    s_data = 32'hDEAD_BEEF;
    repeat (3) tick();
    s_valid = 1'b0;
    check("err1_no_strobe", 32'(strobe_cnt - sb), 32'd0);
    check("err1_no_accept", 32'(acc_cnt - ab), 32'd0);
    check("err1_still_error", 32'(error), 32'd1);
    pulse_start();
    check("err1_cleared", 32'(error), 32'd0);
    check("err1_header_s_ready", 32'(s_ready), 32'd1);

    // Header rejected: zero instruction words
    sb = strobe_cnt;
    send(32'h0000_0004, 0);
    s_valid = 1'b0;
    check("err2_error", 32'(error), 32'd1);
    check("err2_s_ready", 32'(s_ready), 32'd0);
    tick();
    check("err2_no_strobe", 32'(strobe_cnt - sb), 32'd0);
    pulse_start();
    check("err2_cleared", 32'(error), 32'd0);
    check("err2_header_s_ready", 32'(s_ready), 32'd1);

    // 4/4 load with random gaps in s_valid
    ib = iw_a.size();
    db = dw_a.size();
    sb = strobe_cnt;
    ab = acc_cnt;
    load(32'h0004_0004, 32'h1100_0000, 32'h2200_0000, 1'b1);
    finish_check("gap");
    check_writes("gap_i", 1'b1, ib, 4, 32'h1100_0000);
    check_writes("gap_d", 1'b0, db, 4, 32'h2200_0000);
    check("gap_accepts", 32'(acc_cnt - ab), 32'd9);
    check("gap_strobes", 32'(strobe_cnt - sb), 32'd8);

    // Reset after the 3rd instruction word
    pulse_start();
    ib = iw_a.size();
    send(32'h0005_0001, 0);
    for (int k = 0; k < 3; k++) send(32'h3300_0000 + 32'(k), 0);
    check("rst_third_strobe", 32'(i_w_enb), 32'd1);
    rst = 1'b0;
    s_data = 32'h3300_0003;
    tick();
    check_reset_vals("midrst");
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("midrst_i_kept", 32'(iw_a.size() - ib), 32'd3);
    pulse_start();
    ib = iw_a.size();
    db = dw_a.size();
    load(32'h0002_0001, 32'h4400_0000, 32'h5500_0000, 1'b0);
    finish_check("after_rst");
    check_writes("after_rst_i", 1'b1, ib, 2, 32'h4400_0000);
    check_writes("after_rst_d", 1'b0, db, 1, 32'h5500_0000);

    check("never_both_enb", 32'(both_hi), 32'd0);
    check("no_orphan_strobe", 32'(orphan), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
